// File: rtl/flm_alloc.sv
// Self-allocating free-list manager: grants a free ID per accepted request, reclaims IDs on F free ports.
// Optional round-robin grant selection via FLM_ALLOC_RR_EN (default: lowest-index-free).
module flm_alloc #(
  parameter int unsigned N = 16,
  parameter int unsigned F = 2,
  localparam int unsigned W  = $clog2(N),
  localparam int unsigned CW = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  output logic            alloc_rdy,
  output logic [W-1:0]    alloc_id,
  input  logic [F-1:0]    free_vld,
  input  logic [F*W-1:0]  free_id,
  input  logic            clear,
  output logic [N-1:0]    state_r,
  output logic [CW-1:0]   count_r,
  output logic            idle_r,
  output logic            busy_r,
  output logic            err_r
);

  logic [N-1:0]  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          idle_q, idle_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [W-1:0]  id_q, id_d;
`ifdef FLM_ALLOC_RR_EN
  logic [W-1:0]  ptr_q, ptr_d;
`endif

  logic          fire;
  logic [F-1:0]  legal;
  logic [N-1:0]  free_mask;
  logic [CW-1:0] nfree;
  logic          dup, hit;
  logic          found;
  int unsigned   sel;

  assign alloc_rdy = ~busy_q & ~clear;
  assign fire      = alloc_req & alloc_rdy;

  // Legality is judged against the registered state, so an ID granted this cycle cannot be freed.
  always_comb begin
    legal     = '0;
    free_mask = '0;
    nfree     = '0;
    dup       = 1'b0;
    hit       = 1'b0;
    for (int unsigned p = 0; p < F; p++) begin
      dup = 1'b0;
      hit = 1'b0;
      for (int unsigned q = 0; q < p; q++) begin
        if (free_vld[q] && (free_id[q*W +: W] == free_id[p*W +: W])) dup = 1'b1;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (free_id[p*W +: W] == W'(i)) hit = state_q[i];
      end
      legal[p] = free_vld[p] & hit & ~dup;
      for (int unsigned i = 0; i < N; i++) begin
        if (legal[p] && (free_id[p*W +: W] == W'(i))) free_mask[i] = 1'b1;
      end
      nfree = nfree + CW'(legal[p]);
    end
  end

  always_comb begin
    state_d = state_q & ~free_mask;
    for (int unsigned i = 0; i < N; i++) begin
      if (fire && (id_q == W'(i))) state_d[i] = 1'b1;
    end
    count_d = count_q + CW'(fire) - nfree;
    err_d   = err_q | (|(free_vld & ~legal));
`ifdef FLM_ALLOC_RR_EN
    ptr_d = ptr_q;
    if (fire) ptr_d = (id_q == W'(N-1)) ? '0 : id_q + 1'b1;
`endif
    if (clear) begin
      state_d = '0;
      count_d = '0;
      err_d   = 1'b0;
`ifdef FLM_ALLOC_RR_EN
      ptr_d   = '0;
`endif
    end
    idle_d = ~|state_d;
    busy_d = &state_d;

    // Next grant is picked from next-cycle state so alloc_id leaves straight from a flop.
    id_d  = '0;
    found = 1'b0;
    sel   = 0;
    for (int unsigned k = 0; k < N; k++) begin
`ifdef FLM_ALLOC_RR_EN
      sel = int'(ptr_d) + k;
      if (sel >= N) sel = sel - N;
`else
      sel = k;
`endif
      if (!found && !state_d[sel]) begin
        id_d  = W'(sel);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      count_q <= '0;
      idle_q  <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= '0;
`ifdef FLM_ALLOC_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      id_q    <= id_d;
`ifdef FLM_ALLOC_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign alloc_id = id_q;
  assign state_r  = state_q;
  assign count_r  = count_q;
  assign idle_r   = idle_q;
  assign busy_r   = busy_q;
  assign err_r    = err_q;

endmodule

// File: tb/tb_flm_alloc.sv
// Scoreboard bench for flm_alloc: a set-based pool model predicts each cycle's outputs; a monitor compares.
module tb_flm_alloc;
  localparam int N  = 16;
  localparam int F  = 2;
  localparam int W  = 4;
  localparam int CW = 5;

  logic            clk, rst, alloc_req, alloc_rdy, clear;
  logic [W-1:0]    alloc_id;
  logic [F-1:0]    free_vld;
  logic [F*W-1:0]  free_id;
  logic [N-1:0]    state_r;
  logic [CW-1:0]   count_r;
  logic            idle_r, busy_r, err_r;

  flm_alloc #(.N(N), .F(F)) dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_rdy(alloc_rdy), .alloc_id(alloc_id),
    .free_vld(free_vld), .free_id(free_id), .clear(clear), .state_r(state_r), .count_r(count_r),
    .idle_r(idle_r), .busy_r(busy_r), .err_r(err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic          id_chk;
    logic [W-1:0]  id;
    logic [N-1:0]  st;
    logic [CW-1:0] cnt;
    logic          idle, busy, err;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which IDs are held, the sticky error, and the round-robin start point.
  bit held [N];
  bit m_err;
  int m_ptr;

  function automatic int n_held();
    int c = 0;
    for (int i = 0; i < N; i++) c += held[i];
    return c;
  endfunction

  function automatic int pick();
    int start = 0;
`ifdef FLM_ALLOC_RR_EN
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++)
      if (!held[(start + k) % N]) return (start + k) % N;
    return 0;
  endfunction

  function automatic int rand_id();
    int c = n_held();
    int n;
    if (c == 0 || $urandom_range(3) == 0) return int'($urandom_range(N - 1));
    n = int'($urandom_range(c - 1));
    for (int i = 0; i < N; i++)
      if (held[i]) begin
        if (n == 0) return i;
        n--;
      end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) held[i] = 1'b0;
    m_err = 1'b0;
    m_ptr = 0;
  endtask

  task automatic step(input bit req, input bit [1:0] fv, input int f0, input int f1,
                      input bit clr, input bit r);
    exp_t e;
    int ids[2];
    bit lg[2];
    bit full;
    int g;
    alloc_req = req;
    free_vld  = fv;
    free_id   = {4'(f1), 4'(f0)};
    clear     = clr;
    rst       = r;
    full = (n_held() == N);
    e.rdy    = !full && !clr;
    e.id_chk = !full;
    e.id     = W'(pick());
    for (int i = 0; i < N; i++) e.st[i] = held[i];
    e.cnt  = CW'(n_held());
    e.idle = (n_held() == 0);
    e.busy = full;
    e.err  = m_err;
    sb.push_back(e);
    if (r) model_reset();
    else if (clr) model_reset();
    else begin
      g = pick();
      ids[0] = f0; ids[1] = f1;
      for (int p = 0; p < 2; p++) begin
        lg[p] = fv[p] && held[ids[p]] && !(p == 1 && fv[0] && ids[0] == ids[1]);
        if (fv[p] && !lg[p]) m_err = 1'b1;
      end
      for (int p = 0; p < 2; p++) if (lg[p]) held[ids[p]] = 1'b0;
      if (req && e.rdy) begin
        held[g] = 1'b1;
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("alloc_rdy", 32'(alloc_rdy), 32'(e.rdy));
        if (e.id_chk) check("alloc_id", 32'(alloc_id), 32'(e.id));
        check("state_r", 32'(state_r), 32'(e.st));
        check("count_r", 32'(count_r), 32'(e.cnt));
        check("idle_r", 32'(idle_r), 32'(e.idle));
        check("busy_r", 32'(busy_r), 32'(e.busy));
        check("err_r", 32'(err_r), 32'(e.err));
      end
    end
  end

  initial begin : driver
    bit heavy;
    rst = 1'b1; alloc_req = 1'b0; free_vld = '0; free_id = '0; clear = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // reset/idle state
    repeat (2) step(0, 2'b00, 0, 0, 0, 0);
    // fill completely, plus one refused request
    repeat (17) step(1, 2'b00, 0, 0, 0, 0);
    // dual free from full, then reallocate both
    step(0, 2'b11, 3, 7, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    // free while full together with an alloc request
    step(1, 2'b01, 9, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    // illegal frees: unallocated id, then same id on both ports
    step(0, 2'b01, 5, 0, 0, 0);
    step(0, 2'b01, 5, 0, 0, 0);
    step(0, 2'b11, 2, 2, 0, 0);
    repeat (3) step(0, 2'b00, 0, 0, 0, 0);
    // clear overriding alloc and frees at count 9
    step(0, 2'b00, 0, 0, 1, 0);
    repeat (9) step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b11, 1, 2, 1, 0);
    step(0, 2'b00, 0, 0, 0, 0);
    // alloc 0, 1, free 0, alloc; then run to the top and wrap
    step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b01, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    repeat (14) step(1, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 5, 0, 0, 0);
    repeat (3) step(1, 2'b00, 0, 0, 0, 0);
    // reset mid-operation
    step(1, 2'b01, 4, 0, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0);
    // randomized traffic alternating fill-heavy and drain-heavy phases
    for (int c = 0; c < 3000; c++) begin
      heavy = ((c / 80) % 2) == 0;
      step(heavy ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0),
           {1'($urandom_range(heavy ? 5 : 1) == 0), 1'($urandom_range(heavy ? 5 : 1) == 0)},
           rand_id(), rand_id(),
           $urandom_range(299) == 0, $urandom_range(999) == 0);
    end
    step(0, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flm_alloc.md
# flm_alloc

Self-allocating free-list manager: owns a pool of N identifiers, hands out a free ID on each accepted allocation request, and returns IDs through F independent free ports. It is the successor to the plain allocation-state tracker, which relied on the client to choose the ID. This block picks the ID itself, keeps an occupancy count, and flags illegal frees. It sits between ID consumers (ROB/tag/buffer-slot allocators) and completion paths returning IDs.

## Interface
- N, 16: number of IDs; N ≥ 2; IDs 0..N-1
- F, 2: number of free ports; F ≥ 1
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_req  in  1  requester wants an ID this cycle
- alloc_rdy  out  1  an ID is available; equals ~busy_r & ~clear
- alloc_id  out  $clog2(N)  ID granted when alloc_req & alloc_rdy; registered
- free_vld  in  F  per-port free strobe
- free_id  in  F×$clog2(N)  per-port ID being returned
- clear  in  1  return all IDs to the pool
- state_r  out  N  bit i set = ID i allocated
- count_r  out  $clog2(N)+1  number of allocated IDs, 0..N
- idle_r  out  1  no IDs allocated
- busy_r  out  1  all IDs allocated
- err_r  out  1  sticky illegal-free flag

## Operation
- Alloc fire = alloc_req & alloc_rdy. On fire, bit alloc_id of state is set.
- alloc_id is chosen from next-cycle state, then registered. It is therefore valid from flops with zero input-to-output combinational path. It holds the selected free ID whenever alloc_rdy=1, and is don't-care when busy_r=1.
- Selection: lowest-index free ID (see Configuration for round-robin).
- Free port p is legal when all of the following hold:
  - free_vld[p]=1
  - free_id[p] < N
  - state_r[free_id[p]]=1
  - no lower-index port frees the same ID this cycle
- A legal free clears its bit.
- An illegal free is dropped and sets err_r.
- Free of an ID being allocated in the same cycle is illegal, because that ID is free in state_r.
- A freed ID is not allocatable in the same cycle. It becomes eligible from the next cycle.
- count_w = count_r + fire − (number of legal frees). Never wraps; the legality rules guarantee 0 ≤ count_w ≤ N.
- clear has priority over everything:
  - state, count, err_r and the RR pointer all go to 0
  - alloc_rdy is forced low, so no fire occurs
  - frees in the same cycle are ignored and do not flag errors
- idle_r = (state_w == 0) and busy_r = (state_w == all ones), both registered.
- err_r stays set until rst or clear.

## Timing
- Reset values:
  - state_r = 0, count_r = 0
  - idle_r = 1, busy_r = 0, err_r = 0
  - alloc_id = 0
  - alloc_rdy = 1 (when clear = 0)
- Alloc handshake completes in the cycle of fire. The updated state_r, count_r, idle_r, busy_r and the next alloc_id all appear at the following clock edge.
- Back-to-back allocations: one per cycle, with no bubble, until busy.
- Free to visibility (state/count/rdy) is 1 cycle.
- A free and an alloc may occur together while full. alloc_rdy=0 that cycle, and rdy rises the next cycle.
- err_r asserts one cycle after the offending free.
- rst mid-operation discards all state at the edge; there is no drain.

## Configuration
- FLM_ALLOC_RR_EN defined:
  - Round-robin selection using a pointer ptr_r, which resets to 0 and clears to 0 on clear.
  - On fire, ptr_r = alloc_id + 1, wrapping N−1 → 0.
  - alloc_id = first free ID at or after ptr (next-cycle value), searching circularly.
- Not defined:
  - No pointer.
  - Fixed lowest-index-free priority.
  - ptr_r is absent.

## Test plan
- Reset, then idle → state_r=0, count_r=0, idle_r=1, busy_r=0, err_r=0, alloc_rdy=1, alloc_id=0.
- N=16, alloc_req held 16 cycles → ids 0..15 granted consecutively. After the 16th: busy_r=1, count_r=16, alloc_rdy=0. A 17th request is not accepted.
- From full, free ids 3 (port 0) and 7 (port 1) in the same cycle → next cycle count_r=14, busy_r=0, alloc_id=3. After allocating 3, alloc_id=7 (without RR).
- Free unallocated id 5, and on another cycle free id 2 on both ports → err_r=1 one cycle later. id 2 is freed once, and count_r is decremented by 1 only. err_r stays 1 until clear.
- clear with alloc_req=1 and free_vld=11 while count_r=9 → alloc_rdy=0 that cycle. Next cycle state_r=0, count_r=0, idle_r=1, err_r=0.
- Allocate 0 then 1, free 0, then allocate → with FLM_ALLOC_RR_EN the grant is 2; without it the grant is 0. With RR, also allocate through 15 and check the pointer wraps to the lowest free ID.
